// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory, and fills the
// IF/ID latch while honouring decode stalls and execute-stage redirects.
module if_fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [WORD_SIZE-1:0] fetch_pc,
    input  logic [WORD_SIZE-1:0] pred_next_pc,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_pred_pc,
    output logic                 if_valid,
    output logic [WORD_SIZE-1:0] num_fetched
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0] if_instr_q, if_instr_d;
    logic [WORD_SIZE-1:0] if_pc_q, if_pc_d;
    logic [WORD_SIZE-1:0] if_pred_q, if_pred_d;
    logic                 if_valid_q, if_valid_d;
    logic [WORD_SIZE-1:0] num_q, num_d;
    logic [WORD_SIZE-1:0] buf_instr_q, buf_instr_d;
    logic [WORD_SIZE-1:0] buf_pc_q, buf_pc_d;
    logic [WORD_SIZE-1:0] buf_pred_q, buf_pred_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_pred_d   = if_pred_q;
        if_valid_d  = if_valid_q;
        num_d       = num_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_pred_d  = buf_pred_q;

        if (redirect) begin
            if_valid_d  = 1'b0;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            buf_pred_d  = '0;
            pc_d        = redirect_pc;
            // An outstanding request must finish on its original address before refetching.
            if ((state_q == S_FETCH || state_q == S_DRAIN) && !i_ready) begin
                state_d = S_DRAIN;
            end else begin
                req_addr_d = redirect_pc;
                state_d    = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (i_ready) begin
                        pc_d       = pred_next_pc;
                        req_addr_d = pred_next_pc;
                        if (stall) begin
                            buf_instr_d = i_data;
                            buf_pc_d    = pc_q;
                            buf_pred_d  = pred_next_pc;
                            state_d     = S_HOLD;
                        end else begin
                            if_instr_d = i_data;
                            if_pc_d    = pc_q;
                            if_pred_d  = pred_next_pc;
                            if_valid_d = 1'b1;
                            num_d      = num_q + WORD_SIZE'(1);
                        end
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_instr_d = buf_instr_q;
                        if_pc_d    = buf_pc_q;
                        if_pred_d  = buf_pred_q;
                        if_valid_d = 1'b1;
                        num_d      = num_q + WORD_SIZE'(1);
                        state_d    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (i_ready) begin
                        req_addr_d = pc_q;
                        state_d    = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            if_pred_q   <= '0;
            if_valid_q  <= 1'b0;
            num_q       <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_pred_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_pred_q   <= if_pred_d;
            if_valid_q  <= if_valid_d;
            num_q       <= num_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_pred_q  <= buf_pred_d;
        end
    end

    assign fetch_pc    = pc_q;
    assign i_address   = req_addr_q;
    assign i_readM     = (state_q != S_HOLD);
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pred_pc  = if_pred_q;
    assign if_valid    = if_valid_q;
    assign num_fetched = num_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run checked against
// a transaction-level model of the instruction stream delivered into IF/ID.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] fetch_pc, pred_next_pc = 16'h0001, i_address, i_data = 16'h0;
    logic [15:0] redirect_pc = 16'h0, if_instr, if_pc, if_pred_pc, num_fetched;
    logic        i_readM, i_ready = 1'b0, stall = 1'b0, redirect = 1'b0, if_valid;

    int total = 0;
    int bad   = 0;

    int          lat = 1;
    bit          rand_lat = 0, hash_mode = 0, jump_en = 0;
    logic [15:0] jump_src = 16'h0, jump_dst = 16'h0;
    bit          busy = 0;
    int          cnt = 0;
    logic [15:0] req_a = 16'h0;

    always #5 clk = ~clk;

    if_fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .pred_next_pc(pred_next_pc),
        .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_instr(if_instr), .if_pc(if_pc), .if_pred_pc(if_pred_pc),
        .if_valid(if_valid), .num_fetched(num_fetched)
    );

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] pred_fn(input logic [15:0] p);
        if (jump_en && p == jump_src) return jump_dst;
        if (hash_mode && p[2:0] == 3'd5) return p + 16'h0037;
        return p + 16'h0001;
    endfunction

    // Memory model: one request at a time, answers after lat cycles, checks address hold.
    task automatic mem_update();
        if (!reset_n) begin
            busy = 0; i_ready = 1'b0; i_data = 16'h0;
            return;
        end
        if (i_ready) busy = 0;
        i_ready = 1'b0;
        if (!busy && i_readM) begin
            busy = 1; req_a = i_address;
            cnt = rand_lat ? $urandom_range(1, 3) : lat;
        end
        if (busy) begin
            total++;
            if (i_address !== req_a || i_readM !== 1'b1) begin
                bad++;
                $display("FAIL addr_stable: got addr=%h readM=%b want addr=%h readM=1", i_address, i_readM, req_a);
            end
            cnt--;
            if (cnt == 0) begin
                i_ready = 1'b1; i_data = instr_of(req_a);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_update();
        pred_next_pc = pred_fn(fetch_pc);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        lat = 1; rand_lat = 0; hash_mode = 0; jump_en = 0;
        do_reset();
        total++;
        if (if_valid !== 1'b0 || num_fetched !== 16'h0 || if_pc !== 16'h0 || if_instr !== 16'h0 || if_pred_pc !== 16'h0) begin
            bad++;
            $display("FAIL reset_ifid: got v=%b n=%h pc=%h ins=%h pr=%h want all zero", if_valid, num_fetched, if_pc, if_instr, if_pred_pc);
        end
        total++;
        if (fetch_pc !== 16'h0 || i_address !== 16'h0 || i_readM !== 1'b1) begin
            bad++;
            $display("FAIL reset_pc: got pc=%h addr=%h readM=%b want 0000 0000 1", fetch_pc, i_address, i_readM);
        end
        $display("test_reset: done");
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (if_valid !== 1'b1 || if_pc !== 16'(k) || if_instr !== instr_of(16'(k)) || if_pred_pc !== 16'(k + 1) || i_readM !== 1'b1) begin
                bad++;
                $display("FAIL seq_fetch: got v=%b pc=%h ins=%h pr=%h readM=%b want 1 %h %h %h 1",
                         if_valid, if_pc, if_instr, if_pred_pc, i_readM, 16'(k), instr_of(16'(k)), 16'(k + 1));
            end
        end
        total++;
        if (num_fetched !== 16'd3) begin
            bad++;
            $display("FAIL seq_count: got %0d want 3", num_fetched);
        end
        $display("test_sequential: done, num_fetched=%0d", num_fetched);
    endtask

    task automatic test_pred_jump();
        bit found = 0;
        jump_en = 1; jump_src = 16'h0005; jump_dst = 16'h0040;
        do_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (if_valid && if_pc == 16'h0005) found = 1;
        end
        total++;
        if (!found || if_pred_pc !== 16'h0040 || i_address !== 16'h0040) begin
            bad++;
            $display("FAIL pred_jump: got found=%0d pred=%h addr=%h want 1 0040 0040", found, if_pred_pc, i_address);
        end
        tick();
        total++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== instr_of(16'h0040)) begin
            bad++;
            $display("FAIL pred_target: got v=%b pc=%h ins=%h want 1 0040 %h", if_valid, if_pc, if_instr, instr_of(16'h0040));
        end
        jump_en = 0;
        $display("test_pred_jump: done");
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (if_pc !== 16'h0002 || if_instr !== instr_of(16'h0002) || if_valid !== 1'b1 || i_readM !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got pc=%h ins=%h v=%b readM=%b want 0002 %h 1 0", if_pc, if_instr, if_valid, i_readM, instr_of(16'h0002));
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (if_pc !== 16'h0003 || if_instr !== instr_of(16'h0003) || num_fetched !== 16'd4 || i_address !== 16'h0004 || i_readM !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: got pc=%h ins=%h n=%0d addr=%h readM=%b want 0003 %h 4 0004 1",
                     if_pc, if_instr, num_fetched, i_address, i_readM, instr_of(16'h0003));
        end
        tick();
        total++;
        if (if_pc !== 16'h0004 || num_fetched !== 16'd5) begin
            bad++;
            $display("FAIL stall_resume: got pc=%h n=%0d want 0004 5", if_pc, num_fetched);
        end
        $display("test_stall: done");
    endtask

    task automatic test_redirect_pending();
        bit          found = 0;
        logic [15:0] saved;
        lat = 3;
        do_reset();
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (i_address == 16'h0007) found = 1;
        end
        saved = num_fetched;
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        total++;
        if (!found || if_valid !== 1'b0 || i_address !== 16'h0007 || fetch_pc !== 16'h0100 || num_fetched !== saved) begin
            bad++;
            $display("FAIL redir_pend: got found=%0d v=%b addr=%h pc=%h n=%0d want 1 0 0007 0100 %0d", found, if_valid, i_address, fetch_pc, num_fetched, saved);
        end
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (i_address != 16'h0007) found = 1;
        end
        total++;
        if (!found || i_address !== 16'h0100 || num_fetched !== saved || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_drain: got found=%0d addr=%h n=%0d v=%b want 1 0100 %0d 0", found, i_address, num_fetched, if_valid, saved);
        end
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (num_fetched != saved) found = 1;
        end
        total++;
        if (!found || if_pc !== 16'h0100 || num_fetched !== saved + 16'd1) begin
            bad++;
            $display("FAIL redir_refetch: got found=%0d pc=%h n=%0d want 1 0100 %0d", found, if_pc, num_fetched, saved + 16'd1);
        end
        lat = 1;
        $display("test_redirect_pending: done");
    endtask

    task automatic test_redirect_coincident();
        lat = 1;
        do_reset();
        repeat (2) tick();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        stall = 1'b0; redirect = 1'b0;
        total++;
        if (if_valid !== 1'b0 || i_address !== 16'h0100 || i_readM !== 1'b1 || num_fetched !== 16'd2 || fetch_pc !== 16'h0100) begin
            bad++;
            $display("FAIL redir_coinc: got v=%b addr=%h readM=%b n=%0d pc=%h want 0 0100 1 2 0100", if_valid, i_address, i_readM, num_fetched, fetch_pc);
        end
        tick();
        total++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0100 || num_fetched !== 16'd3) begin
            bad++;
            $display("FAIL redir_coinc_next: got v=%b pc=%h n=%0d want 1 0100 3", if_valid, if_pc, num_fetched);
        end
        $display("test_redirect_coincident: done");
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        lat = 3;
        do_reset();
        for (int k = 0; k < 400 && !found; k++) begin
            tick();
            if (i_address == 16'h0020) found = 1;
        end
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++;
        if (!found || i_address !== 16'h0 || if_valid !== 1'b0 || num_fetched !== 16'h0 || fetch_pc !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid: got found=%0d addr=%h v=%b n=%0d pc=%h want 1 0000 0 0 0000", found, i_address, if_valid, num_fetched, fetch_pc);
        end
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick();
            if (num_fetched != 16'h0) found = 1;
        end
        total++;
        if (!found || if_pc !== 16'h0 || num_fetched !== 16'd1 || if_instr !== instr_of(16'h0)) begin
            bad++;
            $display("FAIL reset_mid_refetch: got found=%0d pc=%h n=%0d want 1 0000 1", found, if_pc, num_fetched);
        end
        lat = 1;
        $display("test_reset_mid: done");
    endtask

    // Model: IF/ID must carry the architectural instruction stream implied by the
    // predictor and redirects, one entry per count step, frozen while stalled.
    task automatic test_random();
        logic [15:0] exp_pc, rp, o_instr, o_pc, o_pred, o_num;
        logic        o_valid, p_stall, p_red;
        int          deliveries = 0;
        hash_mode = 1; rand_lat = 1;
        do_reset();
        exp_pc = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            p_stall = ($urandom_range(0, 99) < 30);
            p_red   = ($urandom_range(0, 99) < 4);
            rp      = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            stall = p_stall; redirect = p_red; redirect_pc = rp;
            o_valid = if_valid; o_instr = if_instr; o_pc = if_pc; o_pred = if_pred_pc; o_num = num_fetched;
            tick();
            total++;
            if (p_red) begin
                exp_pc = rp;
                if (if_valid !== 1'b0 || num_fetched !== o_num) begin
                    bad++;
                    $display("FAIL rnd_redirect: got v=%b n=%0d want 0 %0d", if_valid, num_fetched, o_num);
                end
            end else if (num_fetched !== o_num) begin
                deliveries++;
                if (p_stall || num_fetched !== o_num + 16'd1 || if_valid !== 1'b1 || if_pc !== exp_pc ||
                    if_instr !== instr_of(exp_pc) || if_pred_pc !== pred_fn(exp_pc)) begin
                    bad++;
                    $display("FAIL rnd_deliver: got st=%b n=%0d v=%b pc=%h ins=%h pr=%h want 0 %0d 1 %h %h %h",
                             p_stall, num_fetched, if_valid, if_pc, if_instr, if_pred_pc, o_num + 16'd1, exp_pc, instr_of(exp_pc), pred_fn(exp_pc));
                end
                exp_pc = pred_fn(exp_pc);
            end else if (p_stall) begin
                if (if_valid !== o_valid || if_instr !== o_instr || if_pc !== o_pc || if_pred_pc !== o_pred) begin
                    bad++;
                    $display("FAIL rnd_stall_hold: got v=%b pc=%h ins=%h pr=%h want %b %h %h %h", if_valid, if_pc, if_instr, if_pred_pc, o_valid, o_pc, o_instr, o_pred);
                end
            end else if (if_valid !== 1'b0) begin
                bad++;
                $display("FAIL rnd_bubble: got v=%b want 0", if_valid);
            end
        end
        stall = 1'b0; redirect = 1'b0;
        total++;
        if (deliveries < 200) begin
            bad++;
            $display("FAIL rnd_progress: got %0d deliveries want >=200", deliveries);
        end
        hash_mode = 0; rand_lat = 0;
        $display("test_random: done, deliveries=%0d", deliveries);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_pred_jump();
        test_stall();
        test_redirect_pending();
        test_redirect_coincident();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that owns the PC register and sits directly upstream of the branch predictor.
- Drives the fetch PC into the predictor and consumes its predicted next PC to advance.
- Issues requests to instruction memory over a readM/inputReady handshake.
- Delivers instruction, PC and prediction into the IF/ID latch, honouring decode stalls and execute-stage redirects (mispredict/jump).

Parameters:
WORD_SIZE, 16, width of PC, address and instruction
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
fetch_pc  output  WORD_SIZE  current PC, to predictor PC input
pred_next_pc  input  WORD_SIZE  predictor next_PC for fetch_pc (combinational)
i_readM  output  1  instruction memory read request
i_address  output  WORD_SIZE  request address
i_data  input  WORD_SIZE  returned instruction, valid when i_ready=1
i_ready  input  1  memory response strobe (inputReady)
stall  input  1  decode cannot accept; IF/ID must hold
redirect  input  1  mispredict/jump resolved; flush and refetch
redirect_pc  input  WORD_SIZE  correct target PC
if_instr  output  WORD_SIZE  IF/ID instruction
if_pc  output  WORD_SIZE  IF/ID PC
if_pred_pc  output  WORD_SIZE  IF/ID predicted next PC (for branch_sig compare)
if_valid  output  1  IF/ID holds a real instruction
num_fetched  output  WORD_SIZE  count of instructions written into IF/ID

Behaviour:
- Reset (reset_n low at posedge):
  - pc=RESET_PC, req_addr=RESET_PC, state=S_FETCH.
  - if_valid=0, if_instr=0, if_pc=0, if_pred_pc=0, num_fetched=0.
  - Holding buffer cleared.
  - Reset mid-request abandons the request; memory is reset alongside.
- Outputs:
  - fetch_pc=pc.
  - i_address=req_addr (registered).
  - i_readM=1 in S_FETCH and S_DRAIN, 0 in S_HOLD.
- Request rule: address is stable from request start until the i_ready cycle. Memory latency is ≥1 cycle; i_data is sampled only when i_ready=1.
- S_FETCH, i_ready=0: if_valid<=0 unless stall (stall keeps IF/ID).
- S_FETCH, i_ready=1, stall=0:
  - IF/ID <= {i_data, pc, pred_next_pc}, if_valid<=1, num_fetched+=1 (wraps at 2^16).
  - pc<=pred_next_pc, req_addr<=pred_next_pc; stay in S_FETCH.
- S_FETCH, i_ready=1, stall=1:
  - Buffer <= {i_data, pc, pred_next_pc}; pc/req_addr <= pred_next_pc.
  - IF/ID unchanged; go to S_HOLD.
- S_HOLD:
  - While stall=1, wait.
  - When stall=0: IF/ID <= buffer, if_valid<=1, num_fetched+=1, go to S_FETCH (new request next cycle).
- Redirect has highest priority over stall and i_ready in all states:
  - if_valid<=0; buffer discarded; pc<=redirect_pc.
  - In S_FETCH/S_DRAIN with i_ready=0: go to S_DRAIN with req_addr kept (outstanding request must complete).
  - Otherwise (i_ready=1 this cycle, or in S_HOLD): any returned data is discarded, req_addr<=redirect_pc, go to S_FETCH.
- S_DRAIN:
  - Wait for i_ready; the data is discarded and does not count.
  - Then req_addr<=pc, go to S_FETCH.
  - A further redirect in S_DRAIN only updates pc (last one wins).
- stall with if_valid=0 still holds IF/ID (bubble stays a bubble).
- No combinational path from i_data/i_ready to any output. pred_next_pc is used only at the capture edge.
- PC arithmetic is modulo 2^16. 16'hFFFF is a legal address; the predictor handles the wrap.

Test Plan:
- Reset then 1-cycle-latency memory, predictor always PC+1, no stall: fetches at 0x0000,0x0001,0x0002; if_pc follows; num_fetched=3 after third i_ready; i_readM never drops.
- Predictor returns 0x0040 for PC 0x0005: after fetching 0x0005, i_address=0x0040 next request; if_pred_pc=0x0040 alongside if_pc=0x0005.
- stall=1 asserted when 0x0003 returns, held 3 cycles: IF/ID keeps 0x0002 instr; i_readM=0 during hold; on release 0x0003 enters IF/ID next edge, then request 0x0004 issues.
- redirect=1, redirect_pc=0x0100, while request 0x0007 is pending with 3-cycle latency: if_valid=0 next edge; i_address stays 0x0007 until i_ready; that data is discarded (num_fetched unchanged); next request is 0x0100.
- redirect coincident with i_ready and stall: returned data dropped, no S_HOLD, next i_address=0x0100, if_valid=0.
- reset_n low for one cycle mid-request at 0x0020: next cycle i_address=0x0000, if_valid=0, num_fetched=0.
